// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package mem_pkg;

  // ARB: selection is free each cycle. HOLD: selection frozen until the memory grants.
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int NUM_MASTERS_DEF = 2;
  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;

  // Width of a master index / round-robin pointer; at least one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: the first requester at or after ptr, wrapping to index 0.
module rr_select
  import mem_pkg::*;
#(
  parameter int N     = NUM_MASTERS_DEF,
  parameter int PTR_W = ptr_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     sel,
  output logic             valid
);

  // First pass scans indices >= ptr, second pass wraps around from index 0.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        sel[i] = 1'b1;
        valid  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        sel[i] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter placing NUM_MASTERS masters onto one memory port.
//
// Handshake: a request is a level on m_req_i (and on s_req_o toward memory);
// it completes in the cycle where it is selected and s_gnt_i is high, which is
// exactly when m_gnt_o pulses. Without a grant the selection is frozen (HOLD)
// until the memory grants or the held master withdraws. The response arrives
// one cycle after the grant on s_rvalid_i and is routed to the owning master.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]        m_gnt_o,
  output logic [NUM_MASTERS-1:0]        m_rvalid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          s_req_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic                          s_we_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  input  logic                          s_gnt_i,
  input  logic                          s_rvalid_i,
  input  logic [DATA_W-1:0]             s_rdata_i,
  output arb_state_e                    dbg_state
);

  localparam int PTR_W = ptr_w(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       rr_q, owner_q;
  logic [PTR_W-1:0]       sel_idx, sel_next;
  logic                   owner_vld_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [NUM_MASTERS-1:0] hold_sel_q;
  logic [NUM_MASTERS-1:0] rr_sel, cur_sel;
  logic                   rr_vld, cur_vld, gnt;

  rr_select #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req   (m_req_i),
    .ptr   (rr_q),
    .sel   (rr_sel),
    .valid (rr_vld)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end

  // Selection, memory-side mux, grant pass-through and next state.
  always_comb begin
    state_d   = state_q;
    cur_sel   = '0;
    cur_vld   = 1'b0;
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_wdata_o = '0;
    sel_idx   = '0;
    sel_next  = '0;
    if (state_q == HOLD) begin
      // A held master that withdraws leaves nothing selected this cycle.
      cur_sel = hold_sel_q & m_req_i;
      cur_vld = |cur_sel;
    end else begin
      cur_sel = rr_sel;
      cur_vld = rr_vld;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (cur_sel[i]) begin
        s_addr_o  = m_addr_i[i*ADDR_W +: ADDR_W];
        s_we_o    = m_we_i[i];
        s_wdata_o = m_wdata_i[i*DATA_W +: DATA_W];
        sel_idx   = PTR_W'(i);
        sel_next  = (i == NUM_MASTERS - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    s_req_o = cur_vld;
    gnt     = cur_vld & s_gnt_i;
    m_gnt_o = gnt ? cur_sel : '0;
    case (state_q)
      ARB:     if (cur_vld && !s_gnt_i) state_d = HOLD;
      HOLD:    if (!cur_vld || s_gnt_i) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Pointer, held selection, response owner and captured read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      rdata_q     <= '0;
      hold_sel_q  <= '0;
    end else begin
      owner_vld_q <= gnt;
      if (state_q == ARB) hold_sel_q <= cur_sel;
      if (gnt) begin
        rr_q    <= sel_next;
        owner_q <= sel_idx;
        if (!s_we_o) rdata_q <= s_rdata_i;
      end
    end
  end

  // Response routing to the master granted in the previous cycle.
  always_comb begin
    m_rvalid_o = '0;
    if (s_rvalid_i && owner_vld_q) m_rvalid_o[owner_q] = 1'b1;
  end

  assign m_rdata_o = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with four masters, a small memory and a reference model.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NM-1:0]   m_req_i, m_we_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_wdata_i;
  logic [NM-1:0]   m_gnt_o, m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            s_req_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o;
  logic            s_gnt_i;
  logic            s_rvalid_i;
  logic [DW-1:0]   s_rdata_i;
  arb_state_e      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_req_i    (m_req_i),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_wdata_i  (m_wdata_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_wdata_o  (s_wdata_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .dbg_state  (dbg_state)
  );

  function automatic logic [31:0] mem_init(input logic [7:0] a);
    return {8'hC0, a, 8'h5A, ~a};
  endfunction

  // ---------------- memory environment ----------------
  logic [31:0] mem [256];
  logic        mem_rv_q = 1'b0;
  logic        spur = 1'b0;
  assign s_rdata_i  = mem[s_addr_o[7:0]];
  assign s_rvalid_i = mem_rv_q | spur;

  always @(posedge clk) begin
    mem_rv_q <= s_req_o & s_gnt_i;
    if (s_req_o && s_gnt_i && s_we_o) mem[s_addr_o[7:0]] <= s_wdata_o;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer, held master (-1 = none), response owner, memory shadow.
  int          rr_m, held_m, owner_m;
  bit          owner_vld_m;
  logic [31:0] rdata_m;
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];

  // Compare process: predict every output from the rules, then advance the model.
  always @(negedge clk) begin
    int          sel;
    bit          g;
    logic [NM-1:0] e_gnt, e_rv;
    logic [31:0] e_addr, e_wdata;
    bit          e_we;
    if (!rst_n) begin
      rr_m = 0; held_m = -1; owner_m = 0; owner_vld_m = 0; rdata_m = '0;
      exp_q.delete();
    end
    sel = -1;
    if (held_m >= 0) begin
      if (m_req_i[held_m]) sel = held_m;
    end else begin
      for (int i = 0; i < NM; i++)
        if (sel < 0 && m_req_i[(rr_m + i) % NM]) sel = (rr_m + i) % NM;
    end
    g = (sel >= 0) && s_gnt_i;
    e_gnt = '0; e_rv = '0; e_addr = '0; e_wdata = '0; e_we = 0;
    if (sel >= 0) begin
      e_addr  = m_addr_i[sel*AW +: AW];
      e_we    = m_we_i[sel];
      e_wdata = m_wdata_i[sel*DW +: DW];
    end
    if (g) e_gnt[sel] = 1'b1;
    if (owner_vld_m && s_rvalid_i) e_rv[owner_m] = 1'b1;
    chk("s_req",    s_req_o,    sel >= 0);
    chk("s_addr",   s_addr_o,   e_addr);
    chk("s_we",     s_we_o,     e_we);
    chk("s_wdata",  s_wdata_o,  e_wdata);
    chk("m_gnt",    m_gnt_o,    e_gnt);
    chk("m_rvalid", m_rvalid_o, e_rv);
    chk("dbg_state", dbg_state, (held_m >= 0) ? 1 : 0);
    if (owner_vld_m && exp_q.size() > 0) chk("m_rdata_resp", m_rdata_o, exp_q.pop_front());
    chk("m_rdata", m_rdata_o, rdata_m);
    if (rst_n) begin
      if (g) begin
        if (e_we) ref_mem[e_addr[7:0]] = e_wdata;
        else      rdata_m = ref_mem[e_addr[7:0]];
        exp_q.push_back(rdata_m);
        rr_m = (sel + 1) % NM; owner_m = sel; owner_vld_m = 1; held_m = -1;
      end else begin
        owner_vld_m = 0;
        held_m = sel;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0;
    s_gnt_i = 1'b0; spur = 1'b0;
  endtask

  task automatic set_m(input int k, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    m_req_i[k] = req;
    m_we_i[k]  = we;
    m_addr_i[k*AW +: AW]  = addr;
    m_wdata_i[k*DW +: DW] = wdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      clear_inputs();
    end
  endtask

  task automatic do_reset(input int cycles);
    next_cycle();
    clear_inputs();
    rst_n = 1'b0;
    repeat (cycles) next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int ord4 [5] = '{0, 1, 2, 3, 0};
  int ord3 [4] = '{0, 1, 3, 0};

  initial begin
    int ng, nrv;
    bit rv1;
    for (int a = 0; a < 256; a++) begin
      mem[a]     = mem_init(8'(a));
      ref_mem[a] = mem_init(8'(a));
    end
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values.
    @(negedge clk);
    chk("rst_gnt",    m_gnt_o,    4'b0000);
    chk("rst_rvalid", m_rvalid_o, 4'b0000);
    chk("rst_rdata",  m_rdata_o,  32'h0);

    // Two readers, memory always grants: alternate 0,1 with data one cycle later.
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (c == 0) begin
        set_m(0, 1, 0, 32'h10, 32'h0);
        set_m(1, 1, 0, 32'h20, 32'h0);
        s_gnt_i = 1'b1;
      end
      @(negedge clk);
      chk("alt_gnt", m_gnt_o, (c % 2 == 0) ? 4'b0001 : 4'b0010);
      if (c > 0) begin
        chk("alt_rvalid", m_rvalid_o, (c % 2 == 0) ? 4'b0010 : 4'b0001);
        chk("alt_rdata",  m_rdata_o,  (c % 2 == 0) ? 32'hC0205ADF : 32'hC0105AEF);
      end
    end

    // Master 1 writes, then master 0 reads the same address.
    next_cycle();
    set_m(0, 0, 0, 32'h0, 32'h0);
    set_m(1, 1, 1, 32'h4, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_gnt",    m_gnt_o,    4'b0010);
    chk("wr_prev_rv", m_rvalid_o, 4'b0010);
    next_cycle();
    set_m(1, 0, 0, 32'h0, 32'h0);
    set_m(0, 1, 0, 32'h4, 32'h0);
    @(negedge clk);
    chk("rd_gnt",     m_gnt_o,    4'b0001);
    chk("wr_rvalid",  m_rvalid_o, 4'b0010);
    chk("wr_rdata_hold", m_rdata_o, 32'hC0205ADF);
    next_cycle();
    set_m(0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rd_rvalid", m_rvalid_o, 4'b0001);
    chk("rd_rdata",  m_rdata_o,  32'hDEADBEEF);
    idle(2);

    // Memory stalls for 3 cycles with rr at 0: master 0 held, then granted.
    do_reset(2);
    next_cycle();
    set_m(0, 1, 0, 32'h10, 32'h0);
    set_m(1, 1, 0, 32'h20, 32'h0);
    s_gnt_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      chk("stall_addr", s_addr_o, 32'h10);
      chk("stall_gnt",  m_gnt_o,  4'b0000);
    end
    next_cycle();
    s_gnt_i = 1'b1;
    @(negedge clk);
    chk("stall_release", m_gnt_o, 4'b0001);
    next_cycle();
    @(negedge clk);
    chk("stall_next",   m_gnt_o,    4'b0010);
    chk("stall_rvalid", m_rvalid_o, 4'b0001);
    chk("stall_rdata",  m_rdata_o,  32'hC0105AEF);
    idle(2);

    // Single requester for 10 cycles.
    ng = 0; nrv = 0; rv1 = 0;
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      if (c == 0) begin
        set_m(0, 1, 0, 32'h30, 32'h0);
        s_gnt_i = 1'b1;
      end
      if (c == 10) set_m(0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      ng  += int'(m_gnt_o[0]);
      nrv += int'(m_rvalid_o[0]);
      if (m_rvalid_o[1]) rv1 = 1;
    end
    chk("single_grants",  ng,  10);
    chk("single_rvalids", nrv, 10);
    chk("single_rv1",     rv1, 0);
    idle(1);

    // Reset pulse right after a grant drops the response and the pointer.
    next_cycle();
    set_m(0, 1, 0, 32'h10, 32'h0);
    set_m(1, 1, 0, 32'h20, 32'h0);
    s_gnt_i = 1'b1;
    @(negedge clk);
    chk("prerst_gnt", m_gnt_o, 4'b0010);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("inrst_rvalid", m_rvalid_o, 4'b0000);
    chk("inrst_gnt",    m_gnt_o,    4'b0001);
    chk("inrst_rdata",  m_rdata_o,  32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_gnt",    m_gnt_o,    4'b0001);
    chk("postrst_rvalid", m_rvalid_o, 4'b0000);
    next_cycle();
    @(negedge clk);
    chk("postrst_gnt2",   m_gnt_o,    4'b0010);
    chk("postrst_rvalid2", m_rvalid_o, 4'b0001);
    idle(2);

    // Four requesters, then master 2 withdrawn.
    do_reset(1);
    next_cycle();
    for (int k = 0; k < NM; k++) set_m(k, 1, 0, 32'h40 + k, 32'h0);
    s_gnt_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      chk("order4", m_gnt_o, 4'b0001 << ord4[c]);
    end
    idle(1);
    do_reset(1);
    next_cycle();
    for (int k = 0; k < NM; k++) set_m(k, (k != 2), 0, 32'h40 + k, 32'h0);
    s_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      chk("order3", m_gnt_o, 4'b0001 << ord3[c]);
    end
    idle(2);

    // Randomized traffic with stalls, withdrawals, stray rvalid and resets.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 9) < 3) m_req_i[k] = ~m_req_i[k];
        if ($urandom_range(0, 3) == 0) begin
          m_we_i[k] = $urandom_range(0, 1);
          m_addr_i[k*AW +: AW]  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
          m_wdata_i[k*DW +: DW] = $urandom;
        end
      end
      s_gnt_i = ($urandom_range(0, 9) < 7);
      spur    = ($urandom_range(0, 9) == 0);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2 (legal 2..4): number of requesting masters.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port m_req_i  in  NUM_MASTERS  per-master request.
REQ-007 SHALL have port m_addr_i  in  NUM_MASTERS*ADDR_W  per-master address, master k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port m_we_i  in  NUM_MASTERS  per-master write enable.
REQ-009 SHALL have port m_wdata_i  in  NUM_MASTERS*DATA_W  per-master write data.
REQ-010 SHALL have port m_gnt_o  out  NUM_MASTERS  per-master grant, one-hot or zero.
REQ-011 SHALL have port m_rvalid_o  out  NUM_MASTERS  per-master response valid, one-hot or zero.
REQ-012 SHALL have port m_rdata_o  out  DATA_W  shared read data, meaningful only where m_rvalid_o is high.
REQ-013 SHALL have ports s_req_o out 1, s_addr_o out ADDR_W, s_we_o out 1, s_wdata_o out DATA_W: the single memory-side request.
REQ-014 SHALL have ports s_gnt_i in 1, s_rvalid_i in 1, s_rdata_i in DATA_W: memory-side grant, response valid, combinational read data.

Function
REQ-015 SHALL implement states ARB (free to select) and HOLD (selection frozen until memory grants).
REQ-016 In ARB with any m_req_i high, SHALL select the first requesting master at or after round-robin pointer rr_q (wrapping modulo NUM_MASTERS), combinationally, in the same cycle.
REQ-017 SHALL drive s_req_o, s_addr_o, s_we_o and s_wdata_o from the selected master; with no selection, s_req_o=0 and the other s_* outputs=0.
REQ-018 SHALL assert m_gnt_o[k] only in the cycle where master k is selected and s_gnt_i=1 (combinational pass-through of grant).
REQ-019 If the selected master has s_gnt_i=0, SHALL move to HOLD, keeping the same selection on the next cycle regardless of other requests.
REQ-020 In HOLD, SHALL return to ARB on the cycle s_gnt_i=1; if the held master drops m_req_i, SHALL return to ARB with no grant issued.
REQ-021 On every grant to master k, SHALL update rr_q to (k+1) mod NUM_MASTERS.
REQ-022 On every grant, SHALL register owner_q=k and owner_vld_q=1; with no grant, owner_vld_q=0.
REQ-023 On a read grant (we=0), SHALL capture s_rdata_i into rdata_q; on a write grant, rdata_q SHALL hold.
REQ-024 SHALL drive m_rvalid_o[owner_q] = s_rvalid_i & owner_vld_q, all other bits 0; m_rdata_o = rdata_q.
REQ-025 Latency: grant in cycle N gives rvalid and data in cycle N+1; back-to-back grants every cycle SHALL be sustained.
REQ-026 Simultaneous events: a grant in cycle N+1 SHALL NOT disturb the response of the cycle-N grant.
REQ-027 s_rvalid_i high with owner_vld_q=0 SHALL be ignored (no m_rvalid_o).
REQ-028 A single requester SHALL be granted every cycle the memory grants, independent of rr_q.

Reset
REQ-029 On rst_n=0, asynchronously: state=ARB, rr_q=0, owner_q=0, owner_vld_q=0, rdata_q=0; consequently m_rvalid_o=0 and m_rdata_o=0.
REQ-030 Reset during HOLD or with a response pending SHALL drop the transaction; no m_rvalid_o SHALL appear after reset release.
REQ-031 m_gnt_o and s_* outputs during reset SHALL follow the combinational rules with rr_q=0 and state=ARB.

Structure
REQ-032 State enum (ARB, HOLD) and default widths SHALL live in shared package mem_pkg.
REQ-033 Round-robin selection SHALL be one sub-module rr_select (inputs req vector and pointer, output one-hot select and valid).
REQ-034 Arbiter SHALL attach directly to the existing memory module ports without glue logic.

Verification
REQ-035 Masters 0,1 request reads every cycle from 0x10 and 0x20, memory always grants -> grants alternate 0,1,0,1; each rvalid one cycle later to the correct master with mem[0x10]/mem[0x20].
REQ-036 Master 1 writes 0xDEADBEEF to addr 4, then master 0 reads addr 4 -> master 0 gets rvalid with 0xDEADBEEF; master 1 gets rvalid for the write only.
REQ-037 s_gnt_i held 0 for 3 cycles while masters 0,1 request, rr_q=0 -> s_addr_o stays master 0 address all 3 cycles; master 0 granted when s_gnt_i=1.
REQ-038 Master 0 request alone, 10 cycles -> 10 grants, 10 rvalids, m_rvalid_o[1] never high.
REQ-039 rst_n pulsed low in cycle after a grant -> m_rvalid_o stays 0, rr_q=0, first post-reset grant to lowest requester.
REQ-040 NUM_MASTERS=4, all requesting -> grant order 0,1,2,3,0; master 2 dropping request -> order 0,1,3,0.
